fetch_unit: RTL

Instruction-fetch front end that consumes the branch unit's `pc_sel`/`if_kill` outputs. It keeps the fetch PC and issues requests on the instruction-memory valid/ready port. It tracks in-flight requests, discards responses made stale by a redirect, and buffers live instructions with their PCs toward decode. It sits between the branch unit and decode and is the consumer of every redirect the branch unit produces.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end.
//   PcSel      : next-PC selector produced by the branch unit
//   FetchState : fetch FSM states (BOOT until fetch is enabled, then RUN)
package Bundle;

  typedef enum logic [1:0] {
    PC_4     = 2'd0,
    PC_BRJMP = 2'd1,
    PC_JALR  = 2'd2,
    PC_EXC   = 2'd3
  } PcSel;

  typedef enum logic {
    FS_BOOT = 1'b0,
    FS_RUN  = 1'b1
  } FetchState;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req_valid/ready/addr : request channel (fetch unit -> memory)
//   imem_resp_valid/data      : in-order response channel (memory -> fetch unit)
//   dec_valid/ready/inst/pc   : instruction channel (fetch unit -> decode)
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output dec_valid, dec_inst, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  dec_valid, dec_inst, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO used for the PC queue and the instruction queue.
//   push/push_data : enqueue (accepted when not full, or full with a pop)
//   pop            : dequeue (ignored when empty)
//   clear          : drop all entries (wins over push/pop)
//   head           : oldest entry; count : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  // Pointer/occupancy next state; a pop frees the slot a same-cycle push uses.
  always_comb begin
    do_pop_s  = pop & (cnt_q != CW'(0));
    do_push_s = push & ((cnt_q != CW'(DEPTH)) | do_pop_s);
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    if (clear) begin
      rd_d  = AW'(0);
      wr_d  = AW'(0);
      cnt_d = CW'(0);
    end else begin
      rd_d  = do_pop_s  ? rd_q + AW'(1) : rd_q;
      wr_d  = do_push_s ? wr_q + AW'(1) : wr_q;
      cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= AW'(0);
      wr_q  <= AW'(0);
      cnt_q <= CW'(0);
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(0);
    end else if (do_push_s && !clear) begin
      mem_q[wr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
//   clk, reset            : clock, asynchronous active-high reset
//   fetch_en              : lets the FSM leave BOOT
//   pc_sel, if_kill       : redirect/flush from the branch unit
//   br_target, jalr_target, exc_vector : redirect targets
//   bus (master)          : imem request/response and decode channels
// Tracks outstanding requests, discards responses made stale by a redirect
// and queues live {pc, inst} pairs toward decode.
module fetch_unit
  import Bundle::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_2000),
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  PcSel            pc_sel,
  input  logic            if_kill,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] exc_vector,
  fetch_unit_if.master    bus
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  FetchState       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resume_pc_q, resume_pc_d, target_s;
  logic [CW-1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   pcq_cnt_s, occ_s;
  logic [CW1-1:0]  inflight_s;
  logic [XLEN-1:0] pcq_head_s, dec_pc_s, dec_inst_s;
  logic [2*XLEN-1:0] iq_head_s;
  logic run_s, redirect_s, req_valid_s, req_fire_s, dec_valid_s, dec_fire_s;
  logic resp_s, keep_resp_s;

  // A pc_sel redirect without if_kill flushes exactly like a kill.
  assign run_s       = (state_q == FS_RUN);
  assign redirect_s  = if_kill | (pc_sel != PC_4);
  assign inflight_s  = {1'b0, out_cnt_q} + {1'b0, occ_s};
  assign req_valid_s = run_s & ~redirect_s & (inflight_s < CW1'(DEPTH));
  assign req_fire_s  = req_valid_s & bus.imem_req_ready;
  assign dec_valid_s = (occ_s != CW'(0)) & ~redirect_s;
  assign dec_fire_s  = dec_valid_s & bus.dec_ready;
  assign resp_s      = bus.imem_resp_valid;
  // Responses are kept only when nothing stale is still pending ahead of them.
  assign keep_resp_s = resp_s & (drop_cnt_q == CW'(0)) & (pcq_cnt_s != CW'(0)) & ~redirect_s;
  assign dec_pc_s    = iq_head_s[2*XLEN-1:XLEN];
  assign dec_inst_s  = iq_head_s[XLEN-1:0];

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = dec_valid_s;
  assign bus.dec_pc         = dec_pc_s;
  assign bus.dec_inst       = dec_inst_s;

  // FSM next state plus fetch PC, resume PC and counter updates.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resume_pc_d = resume_pc_q;
    out_cnt_d   = out_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    target_s    = resume_pc_q;

    case (state_q)
      FS_BOOT: if (fetch_en) state_d = FS_RUN; else state_d = FS_BOOT;
      FS_RUN:  state_d = FS_RUN;
      default: state_d = FS_BOOT;
    endcase

    // PC_4 during a kill is a fence.i refetch from after the last decoded instruction.
    case (pc_sel)
      PC_BRJMP: target_s = br_target;
      PC_JALR:  target_s = jalr_target;
      PC_EXC:   target_s = exc_vector;
      default:  target_s = resume_pc_q;
    endcase

    if (redirect_s)      fetch_pc_d = target_s;
    else if (req_fire_s) fetch_pc_d = fetch_pc_q + XLEN'(4);
    else                 fetch_pc_d = fetch_pc_q;

    out_cnt_d = out_cnt_q + CW'(req_fire_s) - CW'(resp_s);

    // Everything still in flight after this cycle's return becomes stale on a redirect.
    if (redirect_s)                               drop_cnt_d = out_cnt_q - CW'(resp_s);
    else if (resp_s && (drop_cnt_q != CW'(0)))    drop_cnt_d = drop_cnt_q - CW'(1);
    else                                          drop_cnt_d = drop_cnt_q;

    if (dec_fire_s) resume_pc_d = dec_pc_s + XLEN'(4);
    else            resume_pc_d = resume_pc_q;
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_BOOT;
      fetch_pc_q  <= RESET_PC;
      resume_pc_q <= RESET_PC;
      out_cnt_q   <= CW'(0);
      drop_cnt_q  <= CW'(0);
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resume_pc_q <= resume_pc_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire_s),
    .push_data (fetch_pc_q),
    .pop       (keep_resp_s),
    .clear     (redirect_s),
    .head      (pcq_head_s),
    .count     (pcq_cnt_s)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .reset     (reset),
    .push      (keep_resp_s),
    .push_data ({pcq_head_s, bus.imem_resp_data}),
    .pop       (dec_fire_s),
    .clear     (redirect_s),
    .head      (iq_head_s),
    .count     (occ_s)
  );
endmodule
